// File: rtl/relu_stream_ctrl_pkg.sv
// Shared defaults and FSM encoding for the ReLU stream sequencer.
package relu_stream_ctrl_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDR_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/relu_stream_ctrl_if.sv
// Scheduler/RAM-facing bundle of the ReLU stream sequencer.
interface relu_stream_ctrl_if #(
  parameter int DATA_SIZE = relu_stream_ctrl_pkg::DEF_DATA_SIZE,
  parameter int ADDR_W    = relu_stream_ctrl_pkg::DEF_ADDR_W
);

  logic                 start;
  logic [ADDR_W:0]      len;
  logic [ADDR_W-1:0]    src_base;
  logic [ADDR_W-1:0]    dst_base;
  logic                 hold;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic [ADDR_W:0]      neg_cnt;

  // The master side is the scheduler together with both buffers.
  modport master (
    output start, len, src_base, dst_base, hold, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, neg_cnt
  );

  modport slave (
    input  start, len, src_base, dst_base, hold, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, neg_cnt
  );

endinterface

// File: rtl/relu_stream_ctrl_relu.sv
// Combinational ReLU cell: negative two's-complement words clamp to zero.
module relu_stream_ctrl_relu #(
  parameter int DATA_SIZE = relu_stream_ctrl_pkg::DEF_DATA_SIZE
) (
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 neg
);

  assign neg  = din[DATA_SIZE-1];
  assign dout = neg ? '0 : din;

endmodule

// File: rtl/relu_stream_ctrl.sv
// Streams LEN words from a source buffer through ReLU into a destination buffer.
module relu_stream_ctrl
  import relu_stream_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  relu_stream_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t               state_q, state_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic [ADDR_W:0]      issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]      wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0]      neg_cnt_q, neg_cnt_d;
  logic [ADDR_W-1:0]    src_q, src_d;
  logic [ADDR_W-1:0]    dst_q, dst_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en;
  logic [DATA_SIZE-1:0] relu_data;
  logic                 relu_neg;

  relu_stream_ctrl_relu #(.DATA_SIZE(DATA_SIZE)) u_relu (
    .din  (bus.rd_data),
    .dout (relu_data),
    .neg  (relu_neg)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    src_d       = src_q;
    dst_d       = dst_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    neg_cnt_d   = neg_cnt_q;
    wr_en_d     = rd_vld_q;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    rd_en       = 1'b0;

    // Read data returned this cycle becomes next cycle's registered write.
    if (rd_vld_q) begin
      wr_addr_d = dst_q + wr_cnt_q[ADDR_W-1:0];
      wr_data_d = relu_data;
      wr_cnt_d  = wr_cnt_q + ONE;
      if (relu_neg) begin
        neg_cnt_d = neg_cnt_q + ONE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d       = bus.len;
          src_d       = bus.src_base;
          dst_d       = bus.dst_base;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          neg_cnt_d   = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        // A zero-length job spends one cycle here so done lands two cycles after accept.
        if (len_q == '0) begin
          state_d = ST_FIN;
        end else if (!bus.hold) begin
          rd_en       = 1'b1;
          issue_cnt_d = issue_cnt_q + ONE;
          if (issue_cnt_d == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (wr_en_q && (wr_cnt_q == len_q)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_vld_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      neg_cnt_q   <= '0;
      rd_vld_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      neg_cnt_q   <= neg_cnt_d;
      rd_vld_q    <= rd_vld_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_FIN);
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_en ? (src_q + issue_cnt_q[ADDR_W-1:0]) : '0;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.neg_cnt = neg_cnt_q;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Self-checking bench for relu_stream_ctrl: directed table, reset sequence and random jobs.
module tb_relu_stream_ctrl;
  import relu_stream_ctrl_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_SIZE;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    string tag;
    int    n;
    int    src;
    int    dst;
    int    mode;       // 0 = fixed {5,-3,0,-128} pattern, 1 = random data
    int    hold_from;
    int    hold_cnt;
    int    restart_k;  // -1 none, -2 random cycle inside the busy window
    int    exp_done;   // -1 = model only
    int    exp_neg;    // -1 = model only
  } vec_t;

  typedef struct {
    int k;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  relu_stream_ctrl_if bus ();

  relu_stream_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [DEPTH];

  // Source buffer: synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint outs_flat();
    return longint'({bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.wr_en,
                     bus.wr_addr, bus.wr_data, bus.neg_cnt});
  endfunction

  task automatic run_job(input vec_t v, input int hold_pct);
    logic [DW-1:0] fixed [4];
    bit   hp [];
    ev_t  exp_rd [$];
    ev_t  exp_wr [$];
    ev_t  obs_rd [$];
    ev_t  obs_wr [$];
    int   sz, k, cnt, last, neg, model_done, lim, rk;
    int   first_done, ndone, busy_bad, final_neg;

    fixed[0] = 8'd5; fixed[1] = 8'hFD; fixed[2] = 8'd0; fixed[3] = 8'h80;
    for (int i = 0; i < v.n; i++) begin
      mem[(v.src + i) % DEPTH] = (v.mode == 0) ? fixed[i % 4] : DW'($urandom);
    end

    sz = 3 * v.n + 40;
    hp = new[sz];
    for (int i = 0; i < sz; i++) begin
      hp[i] = ((i >= v.hold_from) && (i < v.hold_from + v.hold_cnt)) ||
              (int'($urandom_range(0, 99)) < hold_pct);
    end

    // Reference: the n reads go to the first n non-held cycles after accept;
    // each write follows its read by two cycles and done follows the last write.
    k = 1; cnt = 0; last = 0; neg = 0;
    while (cnt < v.n) begin
      if (!((k < sz) ? hp[k] : 1'b0)) begin
        int a, d;
        a = (v.src + cnt) % DEPTH;
        d = int'($signed(mem[a]));
        exp_rd.push_back('{k, a, 0});
        if (d < 0) neg++;
        exp_wr.push_back('{k + 2, (v.dst + cnt) % DEPTH, (d < 0) ? 0 : d});
        last = k;
        cnt++;
      end
      k++;
    end
    model_done = (v.n == 0) ? 2 : last + 3;
    rk = (v.restart_k == -2) ? int'($urandom_range(1, model_done)) : v.restart_k;

    first_done = -1; ndone = 0; busy_bad = 0; final_neg = -1;
    lim = model_done + 6;
    for (int c = 0; c <= lim; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 0) || (c == rk);
      if (c == 0) begin
        bus.len      = (AW+1)'(v.n);
        bus.src_base = AW'(v.src);
        bus.dst_base = AW'(v.dst);
      end else if (c == rk) begin
        bus.len      = (AW+1)'(3);
        bus.src_base = AW'(v.src ^ 'h155);
        bus.dst_base = AW'(v.dst ^ 'h0AA);
      end
      bus.hold = (c < sz) ? hp[c] : 1'b0;
      @(negedge clk);
      if (bus.rd_en) obs_rd.push_back('{c, int'(bus.rd_addr), 0});
      if (bus.wr_en) obs_wr.push_back('{c, int'(bus.wr_addr), int'(bus.wr_data)});
      if (bus.done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (bus.busy != ((c >= 1) && (c <= model_done))) busy_bad++;
      if (c == 1) chk({v.tag, " neg_clear"}, longint'(bus.neg_cnt), 0);
      if ((first_done >= 0) && (c == first_done + 1)) final_neg = int'(bus.neg_cnt);
      if ((first_done >= 0) && (c == first_done + 2)) break;
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;

    chk({v.tag, " rd_count"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
      chk($sformatf("%s rd_cycle[%0d]", v.tag, i), obs_rd[i].k, exp_rd[i].k);
      chk($sformatf("%s rd_addr[%0d]", v.tag, i), obs_rd[i].addr, exp_rd[i].addr);
    end
    chk({v.tag, " wr_count"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      chk($sformatf("%s wr_cycle[%0d]", v.tag, i), obs_wr[i].k, exp_wr[i].k);
      chk($sformatf("%s wr_addr[%0d]", v.tag, i), obs_wr[i].addr, exp_wr[i].addr);
      chk($sformatf("%s wr_data[%0d]", v.tag, i), obs_wr[i].data, exp_wr[i].data);
    end
    chk({v.tag, " done_cycle"}, first_done, model_done);
    chk({v.tag, " done_pulses"}, ndone, 1);
    chk({v.tag, " busy_window"}, busy_bad, 0);
    chk({v.tag, " neg_cnt"}, final_neg, neg);
    if (v.exp_done >= 0) chk({v.tag, " done_const"}, first_done, v.exp_done);
    if (v.exp_neg >= 0)  chk({v.tag, " neg_const"}, final_neg, v.exp_neg);

    $display("job %s len=%0d src=%03h dst=%03h restart=%0d reads=%0d writes=%0d done@T+%0d neg=%0d",
             v.tag, v.n, v.src, v.dst, rk, obs_rd.size(), obs_wr.size(), first_done, final_neg);
  endtask

  task automatic midrun_reset();
    int stray;
    for (int i = 0; i < 8; i++) mem[('h100 + i) % DEPTH] = DW'($urandom);
    stray = 0;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 0);
      if (c == 0) begin
        bus.len      = (AW+1)'(8);
        bus.src_base = AW'('h100);
        bus.dst_base = AW'('h300);
      end
      rst = (c == 4);
      @(negedge clk);
      if (c == 5) chk("rst_midrun_outputs", outs_flat(), 0);
      if (c > 5 && (bus.wr_en || bus.busy)) stray++;
    end
    chk("rst_midrun_quiet", stray, 0);
    $display("job rst_midrun len=8 src=100 dst=300 reset@T+4 stray_cycles=%0d", stray);
  endtask

  vec_t tbl [5];

  initial begin
    vec_t v;
    bus.start    = 1'b0;
    bus.hold     = 1'b0;
    bus.len      = '0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.rd_data  = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    tbl[0] = '{"basic4",   4, 'h010, 'h200, 0, 0, 0, -1,  7,  2};
    tbl[1] = '{"len0",     0, 'h020, 'h220, 1, 0, 0, -1,  2,  0};
    tbl[2] = '{"hold2",    6, 'h040, 'h240, 1, 3, 2, -1, 11, -1};
    tbl[3] = '{"wrap",     4, 'h3FE, 'h3FF, 1, 0, 0, -1,  7, -1};
    tbl[4] = '{"restart8", 8, 'h080, 'h280, 1, 0, 0,  2, 11, -1};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", outs_flat(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_job(tbl[i], 0);

    midrun_reset();
    v = '{"post_rst", 8, 'h100, 'h300, 1, 0, 0, -1, 11, -1};
    run_job(v, 0);

    for (int j = 0; j < 25; j++) begin
      v.tag       = $sformatf("rand%0d", j);
      v.n         = int'($urandom_range(0, 40));
      v.src       = int'($urandom_range(0, DEPTH - 1));
      v.dst       = int'($urandom_range(0, DEPTH - 1));
      v.mode      = 1;
      v.hold_from = 0;
      v.hold_cnt  = 0;
      v.restart_k = ($urandom_range(0, 2) == 0) ? -2 : -1;
      v.exp_done  = -1;
      v.exp_neg   = -1;
      run_job(v, 30);
    end

    v = '{"full1024", DEPTH, 'h155, 'h2AA, 1, 0, 0, -1, -1, -1};
    run_job(v, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
